mix_columns_engine: RTL and testbench

Parametrised successor to the single-block MixColumns stage of the AES datapath. It reads NUM_BLOCKS consecutive 128-bit AES states from the shared SRAM and applies forward MixColumns or InvMixColumns to each, selected per run. Each result is written back in place, and completion is reported to the top-level AES controller. The engine owns the SRAM read/write strobes only while busy. Every data path is registered, and the engine tolerates a configurable SRAM read latency.

---
 rtl/mix_columns_engine.sv | 166 ++++++++++++++++
 tb/tb_mix_columns_engine.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_columns_engine.sv
// rtl/mix_columns_engine.sv - multi-block AES (Inv)MixColumns engine over shared SRAM
module mix_columns_engine #(
  parameter int ADDR_W      = 16,
  parameter int BASE_ADDR   = 32,
  parameter int ADDR_STRIDE = 1,
  parameter int NUM_BLOCKS  = 1,
  parameter int READ_LAT    = 2
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              mc_enable,
  input  logic              mc_inverse,
  input  logic [127:0]      sram_read_value,
  output logic [127:0]      sram_write_value,
  output logic              sram_read,
  output logic              sram_write,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              mc_busy,
  output logic              mc_finished
);

  localparam int WCNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    WAIT    = 3'd2,
    COMPUTE = 3'd3,
    WRITE   = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t              state, state_nxt;
  logic [7:0]          blk;
  logic [WCNT_W-1:0]   wcnt;
  logic                inv_q;
  logic [127:0]        data_q;
  logic [127:0]        result_q;
  logic                addr_en;
  logic                last_blk;
  logic [ADDR_W-1:0]   blk_addr;

  // GF(2^8) multiply by x, reducing by the AES polynomial
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by one of the fixed MixColumns coefficients using xtime chains
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (c)
      4'h1:    return x;
      4'h2:    return x2;
      4'h3:    return x2 ^ x;
      4'h9:    return x8 ^ x;
      4'hb:    return x8 ^ x2 ^ x;
      4'hd:    return x8 ^ x4 ^ x;
      4'he:    return x8 ^ x4 ^ x2;
      default: return 8'h00;
    endcase
  endfunction

  // Whole-state transform; row r uses the base coefficient row rotated right by r
  function automatic logic [127:0] mix_state(input logic [127:0] s, input logic inv);
    logic [3:0]   coef [4];
    logic [7:0]   acc;
    logic [127:0] res;
    if (inv) begin
      coef[0] = 4'he; coef[1] = 4'hb; coef[2] = 4'hd; coef[3] = 4'h9;
    end else begin
      coef[0] = 4'h2; coef[1] = 4'h3; coef[2] = 4'h1; coef[3] = 4'h1;
    end
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) begin
          acc = acc ^ gmul(s[127-32*k-8*c -: 8], coef[(k - r + 4) % 4]);
        end
        res[127-32*r-8*c -: 8] = acc;
      end
    end
    return res;
  endfunction

  assign last_blk         = (blk == 8'(NUM_BLOCKS - 1));
  assign blk_addr         = ADDR_W'(BASE_ADDR) + ADDR_W'(blk) * ADDR_W'(ADDR_STRIDE);
  assign sram_addr        = addr_en ? blk_addr : '0;
  assign sram_write_value = result_q;

  // State register; async reset so strobes drop the moment n_rst falls
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and strobe decode
  always_comb begin
    state_nxt   = state;
    sram_read   = 1'b0;
    sram_write  = 1'b0;
    addr_en     = 1'b0;
    mc_busy     = 1'b1;
    mc_finished = 1'b0;
    case (state)
      IDLE: begin
        mc_busy = 1'b0;
        if (mc_enable) state_nxt = READ;
      end
      READ: begin
        sram_read = 1'b1;
        addr_en   = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        addr_en = 1'b1;
        if (wcnt == '0) state_nxt = COMPUTE;
      end
      COMPUTE: state_nxt = WRITE;
      WRITE: begin
        sram_write = 1'b1;
        addr_en    = 1'b1;
        state_nxt  = last_blk ? DONE : READ;
      end
      DONE: begin
        mc_finished = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: mode latch, block/wait counters, data capture and result register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      blk      <= '0;
      wcnt     <= '0;
      inv_q    <= 1'b0;
      data_q   <= '0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mc_enable) begin
            inv_q <= mc_inverse;
            blk   <= '0;
          end
        end
        READ: wcnt <= WCNT_W'(READ_LAT - 1);
        WAIT: begin
          if (wcnt == '0) data_q <= sram_read_value;
          else            wcnt   <= wcnt - 1'b1;
        end
        COMPUTE: result_q <= mix_state(data_q, inv_q);
        WRITE: begin
          if (!last_blk) blk <= blk + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns_engine.sv
// tb/tb_mix_columns_engine.sv - directed self-checking bench for mix_columns_engine
module tb_mix_columns_engine;

  localparam int RL_A = 2;
  localparam int RL_B = 3;

  localparam logic [127:0] V_IN  = 128'hdbf2012d_130a0126_53220131_455c014c;
  localparam logic [127:0] V_OUT = 128'h8e9f014d_4ddc017e_a15801bd_bc9d01f8;
  localparam logic [127:0] R_IN  = 128'h2d01f2db_26010a13_31012253_4c015c45;
  localparam logic [127:0] R_OUT = 128'h4d019f8e_7e01dc4d_bd0158a1_f8019dbc;
  localparam logic [127:0] ALL_C6 = {16{8'hc6}};
  localparam logic [127:0] ALL_01 = {16{8'h01}};
  localparam logic [127:0] STALE  = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [127:0] data;
    logic [31:0] cyc;
  } ev_t;

  bit clk;
  logic [31:0] cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  logic a_n_rst, a_en, a_inv, a_rd, a_wr, a_busy, a_fin;
  logic [127:0] a_rdata, a_wdata;
  logic [15:0] a_addr;
  logic b_n_rst, b_en, b_inv, b_rd, b_wr, b_busy, b_fin;
  logic [127:0] b_rdata, b_wdata;
  logic [15:0] b_addr;

  logic [127:0] mem_a [64];
  logic [127:0] mem_b [64];
  bit a_pv [RL_A];
  bit b_pv [RL_B];
  logic [15:0] a_pa [RL_A];
  logic [15:0] b_pa [RL_B];
  bit a_both = 1'b0;
  bit b_both = 1'b0;
  ev_t a_log[$];
  ev_t b_log[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  mix_columns_engine #(.ADDR_W(16), .BASE_ADDR(32), .ADDR_STRIDE(1), .NUM_BLOCKS(1), .READ_LAT(RL_A)) u_dut_a (
    .clk(clk), .n_rst(a_n_rst), .mc_enable(a_en), .mc_inverse(a_inv),
    .sram_read_value(a_rdata), .sram_write_value(a_wdata), .sram_read(a_rd),
    .sram_write(a_wr), .sram_addr(a_addr), .mc_busy(a_busy), .mc_finished(a_fin));

  mix_columns_engine #(.ADDR_W(16), .BASE_ADDR(32), .ADDR_STRIDE(1), .NUM_BLOCKS(3), .READ_LAT(RL_B)) u_dut_b (
    .clk(clk), .n_rst(b_n_rst), .mc_enable(b_en), .mc_inverse(b_inv),
    .sram_read_value(b_rdata), .sram_write_value(b_wdata), .sram_read(b_rd),
    .sram_write(b_wr), .sram_addr(b_addr), .mc_busy(b_busy), .mc_finished(b_fin));

  // SRAM models: data valid exactly READ_LAT edges after the read cycle, stale otherwise
  assign a_rdata = a_pv[RL_A-1] ? mem_a[a_pa[RL_A-1][5:0]] : STALE;
  assign b_rdata = b_pv[RL_B-1] ? mem_b[b_pa[RL_B-1][5:0]] : STALE;

  always @(posedge clk) begin
    for (int i = RL_A - 1; i > 0; i--) begin
      a_pv[i] <= a_pv[i-1];
      a_pa[i] <= a_pa[i-1];
    end
    a_pv[0] <= a_rd;
    a_pa[0] <= a_addr;
    if (a_rd || a_wr) a_log.push_back('{a_wr, a_addr, a_wdata, cyc});
    if (a_rd && a_wr) a_both <= 1'b1;
  end

  always @(posedge clk) begin
    for (int i = RL_B - 1; i > 0; i--) begin
      b_pv[i] <= b_pv[i-1];
      b_pa[i] <= b_pa[i-1];
    end
    b_pv[0] <= b_rd;
    b_pa[0] <= b_addr;
    if (b_rd || b_wr) b_log.push_back('{b_wr, b_addr, b_wdata, cyc});
    if (b_rd && b_wr) b_both <= 1'b1;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic ev_t get_a(input int idx);
    return (idx < a_log.size()) ? a_log[idx] : '0;
  endfunction

  function automatic ev_t get_b(input int idx);
    return (idx < b_log.size()) ? b_log[idx] : '0;
  endfunction

  task automatic run_a(input string tag, input logic inv, input logic [127:0] din, input logic [127:0] dout);
    int s, fin_at, busy_n;
    logic [31:0] base;
    ev_t r, w;
    mem_a[32] = din;
    s = a_log.size();
    fin_at = 0;
    busy_n = 0;
    base = 0;
    @(negedge clk);
    a_en = 1'b1;
    a_inv = inv;
    @(posedge clk);
    #1;
    a_en = 1'b0;
    a_inv = ~inv;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) base = cyc;
      if (a_busy) busy_n++;
      if (a_fin && fin_at == 0) fin_at = i;
    end
    r = get_a(s);
    w = get_a(s + 1);
    check({tag, "_fin_cycle"}, 128'(fin_at), 128'd6);
    check({tag, "_busy_cycles"}, 128'(busy_n), 128'd6);
    check({tag, "_access_count"}, 128'(a_log.size() - s), 128'd2);
    check({tag, "_read"}, {r.wr, r.addr, r.cyc - base + 32'd1}, {1'b0, 16'd32, 32'd1});
    check({tag, "_write"}, {w.wr, w.addr, w.cyc - base + 32'd1}, {1'b1, 16'd32, 32'd5});
    check({tag, "_wdata"}, w.data, dout);
  endtask

  task automatic run_b(input string tag, input logic hold);
    int s, fin_n, fin_first, busy_n;
    logic idle20;
    logic [31:0] base;
    logic [127:0] exp_d [3];
    ev_t e;
    exp_d[0] = V_OUT;
    exp_d[1] = ALL_C6;
    exp_d[2] = R_OUT;
    s = b_log.size();
    fin_n = 0;
    fin_first = 0;
    busy_n = 0;
    idle20 = 1'b1;
    base = 0;
    @(negedge clk);
    b_en = 1'b1;
    b_inv = 1'b0;
    @(posedge clk);
    #1;
    if (!hold) b_en = 1'b0;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      if (i == 1) base = cyc;
      if (i <= 19 && b_busy) busy_n++;
      if (i == 20) idle20 = b_busy;
      if (b_fin) begin
        fin_n++;
        if (fin_first == 0) fin_first = i;
      end
      if (i == 21) b_en = 1'b0;
    end
    check({tag, "_fin_first"}, 128'(fin_first), 128'd19);
    check({tag, "_fin_count"}, 128'(fin_n), hold ? 128'd2 : 128'd1);
    check({tag, "_busy_cycles"}, 128'(busy_n), 128'd19);
    check({tag, "_idle_after_done"}, 128'(idle20), 128'd0);
    check({tag, "_access_count"}, 128'(b_log.size() - s), hold ? 128'd12 : 128'd6);
    for (int k = 0; k < 6; k++) begin
      e = get_b(s + k);
      check($sformatf("%s_ev%0d", tag, k), {e.wr, e.addr, e.cyc - base + 32'd1},
            {k[0], 16'(32 + k / 2), 32'(k[0] ? 6 * (k / 2) + 6 : 6 * (k / 2) + 1)});
      if (k[0]) check($sformatf("%s_wdata%0d", tag, k / 2), e.data, exp_d[k / 2]);
    end
    if (hold) begin
      e = get_b(s + 6);
      check({tag, "_restart"}, {e.wr, e.addr, e.cyc - base + 32'd1}, {1'b0, 16'd32, 32'd21});
    end
  endtask

  initial begin
    int s, fin_n, busy_n;
    ev_t e;
    a_n_rst = 1'b0; a_en = 1'b0; a_inv = 1'b0;
    b_n_rst = 1'b0; b_en = 1'b0; b_inv = 1'b0;
    mem_b[32] = V_IN;
    mem_b[33] = ALL_C6;
    mem_b[34] = R_IN;
    #3;
    check("reset_a", {a_wdata, a_rd, a_wr, a_addr, a_busy, a_fin}, '0);
    check("reset_b", {b_wdata, b_rd, b_wr, b_addr, b_busy, b_fin}, '0);
    repeat (2) @(negedge clk);
    a_n_rst = 1'b1;
    b_n_rst = 1'b1;
    repeat (2) @(negedge clk);

    run_a("fwd", 1'b0, V_IN, V_OUT);
    run_a("inv", 1'b1, V_OUT, V_IN);
    run_a("fix_c6_fwd", 1'b0, ALL_C6, ALL_C6);
    run_a("fix_01_inv", 1'b1, ALL_01, ALL_01);
    run_a("fix_c6_inv", 1'b1, ALL_C6, ALL_C6);
    run_a("fwd_rev", 1'b0, R_IN, R_OUT);

    run_b("multi", 1'b0);
    run_b("hold_en", 1'b1);
    repeat (3) @(negedge clk);

    s = b_log.size();
    @(negedge clk);
    b_en = 1'b1;
    @(posedge clk);
    #1;
    b_en = 1'b0;
    repeat (8) @(negedge clk);
    #2;
    b_n_rst = 1'b0;
    #1;
    check("rst_async", {b_wdata, b_rd, b_wr, b_addr, b_busy, b_fin}, '0);
    repeat (2) @(negedge clk);
    b_n_rst = 1'b1;
    fin_n = 0;
    busy_n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (b_fin) fin_n++;
      if (b_busy) busy_n++;
    end
    e = get_b(s + 2);
    check("rst_access_count", 128'(b_log.size() - s), 128'd3);
    check("rst_last_access", {e.wr, e.addr}, {1'b0, 16'd33});
    check("rst_no_finish", 128'(fin_n), 128'd0);
    check("rst_idle", 128'(busy_n), 128'd0);
    check("rw_exclusive", {a_both, b_both}, '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
